// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types for the dual-port RAM with clear sweep
package bram_pkg;

  // Clear sequencer states: idle serves user traffic, clear owns the write port
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/bram_dp_clear_if.sv
// rtl/bram_dp_clear_if.sv - port A/B access and clear control bundle
interface bram_dp_clear_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) ();

  logic                  a_en;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  clear_req;
  logic                  busy;
  logic                  clear_done;

  modport master (
    output a_en, a_we, a_addr, a_wdata, b_en, b_addr, clear_req,
    input  a_rdata, b_rdata, busy, clear_done
  );

  modport slave (
    input  a_en, a_we, a_addr, a_wdata, b_en, b_addr, clear_req,
    output a_rdata, b_rdata, busy, clear_done
  );

endinterface

// File: rtl/bram_sdp_array.sv
// rtl/bram_sdp_array.sv - reset-free storage, one write port, two synchronous read ports
module bram_sdp_array #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int WRITE_FIRST = 0
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  a_re_i,
  input  logic [ADDR_WIDTH-1:0] a_raddr_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_re_i,
  input  logic [ADDR_WIDTH-1:0] b_raddr_i,
  output logic [DATA_WIDTH-1:0] b_rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic                  a_hit;
  logic                  b_hit;

  // Bypass only exists in write-first mode; read-first naturally sees the old word
  assign a_hit = (WRITE_FIRST != 0) && we_i && (waddr_i == a_raddr_i);
  assign b_hit = (WRITE_FIRST != 0) && we_i && (waddr_i == b_raddr_i);

  // Single write port; user and sweep writes are already muxed by the caller
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Port A read register, holds when not enabled
  always_ff @(posedge clk_i) begin
    if (a_re_i) a_rdata_q <= a_hit ? wdata_i : mem_q[a_raddr_i];
  end

  // Port B read register, holds when not enabled
  always_ff @(posedge clk_i) begin
    if (b_re_i) b_rdata_q <= b_hit ? wdata_i : mem_q[b_raddr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/bram_dp_clear.sv
// rtl/bram_dp_clear.sv - dual-port RAM top with clear sweep and optional output register
module bram_dp_clear
  import bram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    OUT_REG     = 0,
  parameter int                    WRITE_FIRST = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic            clk,
  input logic            rst_n,
  bram_dp_clear_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  a_en_g;
  logic                  b_en_g;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] a_raw;
  logic [DATA_WIDTH-1:0] b_raw;
  logic                  a_seen_q;
  logic                  b_seen_q;
  logic [DATA_WIDTH-1:0] a_stage;
  logic [DATA_WIDTH-1:0] b_stage;

  // Clear sequencer: sweeps 0..max one word per cycle, pulses done on the last write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clear_req) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_ONE;
          if (cnt_q == ADDR_MAX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // User accesses are invisible to the array while the sweep owns it
  assign a_en_g = bus.a_en & ~busy_q;
  assign b_en_g = bus.b_en & ~busy_q;

  // Write-port mux: sweep has priority, otherwise the qualified user write
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.a_addr;
    wr_data = bus.a_wdata;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = CLEAR_VALUE;
    end else begin
      wr_en = bus.a_en & bus.a_we;
    end
  end

  bram_sdp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WRITE_FIRST(WRITE_FIRST)
  ) u_array (
    .clk_i    (clk),
    .we_i     (wr_en),
    .waddr_i  (wr_addr),
    .wdata_i  (wr_data),
    .a_re_i   (a_en_g),
    .a_raddr_i(bus.a_addr),
    .a_rdata_o(a_raw),
    .b_re_i   (b_en_g),
    .b_raddr_i(bus.b_addr),
    .b_rdata_o(b_raw)
  );

  // Array read registers carry no reset; force 0 until each port has read since reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_seen_q <= 1'b0;
      b_seen_q <= 1'b0;
    end else begin
      if (a_en_g) a_seen_q <= 1'b1;
      if (b_en_g) b_seen_q <= 1'b1;
    end
  end

  assign a_stage = a_seen_q ? a_raw : '0;
  assign b_stage = b_seen_q ? b_raw : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  a_en_prev_q;
      logic                  b_en_prev_q;
      logic [DATA_WIDTH-1:0] a_out_q;
      logic [DATA_WIDTH-1:0] b_out_q;

      // Output stage loads only behind a cycle in which that port actually read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_en_prev_q <= 1'b0;
          b_en_prev_q <= 1'b0;
          a_out_q     <= '0;
          b_out_q     <= '0;
        end else begin
          a_en_prev_q <= a_en_g;
          b_en_prev_q <= b_en_g;
          if (a_en_prev_q) a_out_q <= a_stage;
          if (b_en_prev_q) b_out_q <= b_stage;
        end
      end

      assign bus.a_rdata = a_out_q;
      assign bus.b_rdata = b_out_q;
    end else begin : g_no_out_reg
      assign bus.a_rdata = a_stage;
      assign bus.b_rdata = b_stage;
    end
  endgenerate

  assign bus.busy       = busy_q;
  assign bus.clear_done = done_q;

endmodule

// File: doc/bram_dp_clear.md
# bram_dp_clear

Dual-port block RAM for the data tape and program store. Port A reads and writes; port B is read-only. Output register and read-during-write behaviour are selectable by parameter. A built-in clear sequencer sweeps every word to a fixed value on request, so the tape can be zeroed at program start without CPU cycles.

## Interface
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width in bits
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1)
- WRITE_FIRST, 0, 1 = a read of the address being written returns new data; 0 = returns old data
- CLEAR_VALUE, 0, value (DATA_WIDTH bits) written by the clear sweep
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- a_en  in  1  port A access enable
- a_we  in  1  port A write enable (qualified by a_en)
- a_addr  in  ADDR_WIDTH  port A address
- a_wdata  in  DATA_WIDTH  port A write data
- a_rdata  out  DATA_WIDTH  port A read data
- b_en  in  1  port B read enable
- b_addr  in  ADDR_WIDTH  port B address
- b_rdata  out  DATA_WIDTH  port B read data
- clear_req  in  1  start clear sweep (level, sampled in IDLE)
- busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when sweep finishes

## Operation
- States: IDLE, CLEAR. IDLE→CLEAR when clear_req=1 at a clock edge. CLEAR→IDLE after the write to address 2**ADDR_WIDTH-1.
- In CLEAR, a counter drives the write address 0,1,…,max, one word per cycle, with data CLEAR_VALUE.
- While busy=1, a_en and b_en are ignored: user writes are dropped and a_rdata/b_rdata hold their values. clear_req is also ignored while busy=1.
- Port A write (a_en&a_we): mem[a_addr]←a_wdata. Port A read data follows the WRITE_FIRST rule for its own address.
- Collision (A writes address X, B reads X in the same cycle): b_rdata = a_wdata if WRITE_FIRST=1, else the old mem[X].
- en=0 on a port: that port's rdata holds (both raw and OUT_REG stages).
- Reset affects control and output registers only: state→IDLE, counter→0, busy→0, clear_done→0, a_rdata→0, b_rdata→0, pipeline regs→0.
- Memory contents are never reset. They are undefined after power-up. Reset asserted mid-sweep aborts the sweep; addresses already swept stay cleared, the rest are unchanged.

## Timing
- Read latency: with OUT_REG=0, rdata is valid 1 edge after en; with OUT_REG=1, 2 edges after. Back-to-back reads give one result per cycle.
- The OUT_REG stage advances only when that port's enable from the previous cycle was 1.
- clear_req high at edge t: busy=1 after t. Edges t+1…t+2**ADDR_WIDTH write addresses 0…max. At edge t+2**ADDR_WIDTH, busy→0 and clear_done→1 for exactly one cycle.
- A user access presented in the same cycle clear_req is sampled is performed (it is still IDLE). The first access accepted after the sweep is at the edge where clear_done=1.
- clear_req held high continuously re-triggers a new sweep starting the cycle after clear_done.

## Structure
- Package bram_pkg holds the state enum typedef (IDLE, CLEAR).
- One sub-module, bram_sdp_array: the raw storage with one write port and two synchronous read ports plus the WRITE_FIRST bypass, kept free of reset so synthesis infers block RAM.
- The top level holds the clear FSM/counter, the write-port mux (user vs. sweep), enable gating and the optional output registers.

## Test plan
- Reset release, then a_we to 0x005 with 0xA7, then b read of 0x005 -> b_rdata=0xA7 one edge later (OUT_REG=0), two edges later (OUT_REG=1).
- Collision: A writes 0x3C to 0x010 (old value 0x11) while B reads 0x010 -> b_rdata=0x3C with WRITE_FIRST=1, 0x11 with WRITE_FIRST=0.
- Fill memory with a non-zero pattern, pulse clear_req -> busy high for exactly 1024 cycles, clear_done pulses once, every address reads CLEAR_VALUE.
- During busy, issue an A write of 0xFF to 0x020 and B reads -> write dropped (0x020 reads CLEAR_VALUE afterwards), rdata held constant.
- Assert rst_n low at sweep address 0x200 -> busy=0, clear_done=0 and outputs 0 immediately; addresses <0x200 read CLEAR_VALUE, addresses ≥0x201 keep the old pattern.
- en low for 3 cycles after a read of 0x7E -> a_rdata holds 0x7E throughout.
